i281_instr_fetch: RTL and testbench
===================================

# i281_instr_fetch

Instruction fetch stage of the i281 CPU, directly downstream of the user code ROMs. It holds the program counter, selects one 16-bit word from the 32-word program presented by the low/high user code blocks, and registers it into a one-deep instruction register. The decoder consumes that register through a valid/ready handshake. The stage supports free-run, single-step and branch redirect.

## Interface

**Parameters**
- `RESET_PC`, default 5'd0: PC value loaded on reset.

**Ports**
- `Clock`, input, 1: rising-edge system clock.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `code_low`, input, 256: user code words 0–15; word k is at bits [16k+15:16k].
- `code_high`, input, 256: user code words 16–31, same packing (word 16+k at [16k+15:16k]).
- `run`, input, 1: level; 1 = free-running fetch.
- `step`, input, 1: single-step request; edge-detected internally.
- `redirect_valid`, input, 1: branch/jump taken this cycle.
- `redirect_pc`, input, 5: new fetch address.
- `instr`, output, 16: registered instruction word.
- `instr_pc`, output, 5: address `instr` was fetched from.
- `instr_valid`, output, 1: `instr` holds an unconsumed instruction.
- `instr_ready`, input, 1: decoder accepts `instr` this cycle.
- `pc`, output, 5: next fetch address.
- `fetch_count`, output, 16: instructions accepted, saturating.
- `mode`, output, 2: state encoding.

## Operation

- **Word select:** `pc[4]=0` selects `code_low` word `pc[3:0]`; `pc[4]=1` selects `code_high` word `pc[3:0]`. Purely combinational from `pc`.
- **Load condition:** a load may occur when `(!instr_valid || instr_ready)` is true, the state permits it, and `redirect_valid=0`.
- **On load:**
  - `instr` <= selected word, `instr_pc` <= `pc`, `instr_valid` <= 1.
  - `pc` <= `pc+1`, modulo 32; 31 wraps to 0.
- **Accept:** occurs when `instr_valid && instr_ready`. If no load happens in the same cycle, `instr_valid` <= 0.
- **`fetch_count`:** +1 on every accept; holds at 16'hFFFF. Cleared only by reset.
- **Step edge:** `step_q` is a registered copy of `step`; `step_edge = step & ~step_q`.
- **State machine** (`mode` encoding: IDLE=00, RUN=01, STEP=10, DRAIN=11):
  - IDLE: no loads. `run=1` -> RUN; else `step_edge` -> STEP. `run` has priority.
  - RUN: load whenever the load condition holds. `run=0` -> DRAIN.
  - STEP: perform exactly one load, then -> DRAIN in the same clock edge as that load.
  - DRAIN: no loads. When `instr_valid=0`, or an accept occurs this cycle -> IDLE.
  - `step_edge` is ignored outside IDLE.
- **Redirect** (highest priority, any state):
  - `pc` <= `redirect_pc` and `instr_valid` <= 0 (flush); no load that cycle.
  - An accept coinciding with the redirect still counts toward `fetch_count`.
  - State is unchanged. A STEP interrupted by a redirect performs its single load on the next eligible cycle.

## Timing

- **Reset values** (asynchronous, immediate on `Reset_n=0`):
  - `pc`=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0.
  - `fetch_count`=0, `mode`=00 (IDLE), `step_q`=0.
- **Latency:** state enters RUN one edge after `run` is sampled high. The first load happens on the following edge, so `instr_valid` rises 2 cycles after `run` is first sampled.
- **Throughput:** one instruction per cycle while `instr_ready=1`.
- **Backpressure:** while `instr_valid=1` and `instr_ready=0`, `instr`, `instr_pc` and `pc` hold.
- **Redirect:** `instr_valid` is low for exactly one cycle. The target word is presented one cycle later in RUN.
- **Register discipline:** all outputs are registered; no combinational path from `instr_ready` or `redirect_valid` to outputs.

## Test plan

1. **Free run and wrap:** reset with word0=16'hD300, word1=16'hF104, word17=16'h1234, `run=1`, `instr_ready=1` -> `instr_pc` sequence 0,1,…,31,0 on consecutive cycles. `instr`=16'hD300 at PC0 and 16'h1234 at PC17. `fetch_count` increments by one per cycle.
2. **Backpressure:** in RUN, drop `instr_ready` for 3 cycles at `instr_pc`=5 -> `instr`, `instr_pc`=5 and `pc`=6 stable for 3 cycles, `fetch_count` frozen. Resumes with PC6 on the cycle after ready returns.
3. **Redirect with simultaneous accept:** while `instr_valid=1`, `instr_ready=1`, assert `redirect_valid` with `redirect_pc`=20 -> `fetch_count`+1. The next cycle has `instr_valid=0`; the cycle after has `instr_pc`=20 and `instr`=`code_high` word 4.
4. **Single step:** `run=0`, hold `step` high 5 cycles, `instr_ready=0` -> exactly one load (PC0) and `mode`=11. After `instr_ready` pulses: `mode`=00, `pc`=1, `fetch_count`=1.
5. **Run drop mid-stream:** deassert `run` with `instr_valid=1`, `instr_ready=0` -> `mode`=11 and the held instruction is unchanged. Once accepted, `mode`=00 and no further loads occur.
6. **Reset mid-run:** assert `Reset_n=0` between clock edges in RUN -> all outputs reach reset values without a clock edge. After release, fetch restarts from `RESET_PC` only when `run` is sampled high.

Source files
------------

// File: rtl/i281_instr_fetch.sv
// i281 instruction fetch: program counter, code word select from the user code
// ROMs, and a one-deep instruction register drained by the decoder via valid/ready.
module i281_instr_fetch #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic [255:0] code_low,
  input  logic [255:0] code_high,
  input  logic         run,
  input  logic         step,
  input  logic         redirect_valid,
  input  logic [4:0]   redirect_pc,
  output logic [15:0]  instr,
  output logic [4:0]   instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [4:0]   pc,
  output logic [15:0]  fetch_count,
  output logic [1:0]   mode
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t      state, state_next;
  logic        step_q;
  logic        step_edge;
  logic        load_permit;
  logic        load;
  logic        accept;
  logic [7:0]  word_base;
  logic [15:0] word;

  assign word_base = {pc[3:0], 4'b0000};
  assign word      = pc[4] ? code_high[word_base +: 16] : code_low[word_base +: 16];
  assign step_edge = step & ~step_q;
  assign accept    = instr_valid & instr_ready;
  assign load      = load_permit & (~instr_valid | instr_ready) & ~redirect_valid;
  assign mode      = state;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      step_q <= 1'b0;
    end else begin
      state  <= state_next;
      step_q <= step;
    end
  end

  // A redirect freezes the state, so an interrupted STEP still owes its load.
  always_comb begin
    state_next = state;
    if (!redirect_valid) begin
      case (state)
        IDLE: begin
          if (run)
            state_next = RUN;
          else if (step_edge)
            state_next = STEP;
        end
        RUN: begin
          if (!run)
            state_next = DRAIN;
        end
        STEP: begin
          if (load)
            state_next = DRAIN;
        end
        DRAIN: begin
          if (!instr_valid || accept)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    load_permit = 1'b0;
    case (state)
      RUN:     load_permit = 1'b1;
      STEP:    load_permit = 1'b1;
      default: load_permit = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_pc    <= 5'd0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= word;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      pc          <= pc + 5'd1;
    end else if (accept) begin
      instr_valid <= 1'b0;
    end
  end

  // Accepts count even when a redirect flushes the register in the same cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      fetch_count <= 16'h0000;
    else if (accept && (fetch_count != 16'hFFFF))
      fetch_count <= fetch_count + 16'h0001;
  end

endmodule

// File: tb/tb_i281_instr_fetch.sv
// Self-checking bench for i281_instr_fetch: a per-cycle reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_i281_instr_fetch;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_RUN   = 2'd1;
  localparam logic [1:0] M_STEP  = 2'd2;
  localparam logic [1:0] M_DRAIN = 2'd3;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic [255:0] code_low;
  logic [255:0] code_high;
  logic         run;
  logic         step;
  logic         redirect_valid;
  logic [4:0]   redirect_pc;
  logic [15:0]  instr;
  logic [4:0]   instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic [4:0]   pc;
  logic [15:0]  fetch_count;
  logic [1:0]   mode;

  logic [15:0] code_mem [32];
  int          checks = 0;
  int          errors = 0;
  bit          cmp_on = 1'b0;

  logic [4:0]  m_pc = 5'd0;
  logic [15:0] m_instr = 16'h0000;
  logic [4:0]  m_instr_pc = 5'd0;
  logic        m_valid = 1'b0;
  logic [15:0] m_count = 16'h0000;
  logic [1:0]  m_mode = M_IDLE;
  logic        m_step_q = 1'b0;
  logic        m_acc;
  logic        m_edge;
  logic        m_load;
  logic        m_prev_valid;

  i281_instr_fetch #(.RESET_PC(5'd0)) dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .code_low       (code_low),
    .code_high      (code_high),
    .run            (run),
    .step           (step),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc             (pc),
    .fetch_count    (fetch_count),
    .mode           (mode)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit rv, input logic [4:0] rp, input bit rdy);
    run            = r;
    step           = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    instr_ready    = rdy;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Reference model: the program is an array indexed by PC, one update per edge.
  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc       = 5'd0;
      m_instr    = 16'h0000;
      m_instr_pc = 5'd0;
      m_valid    = 1'b0;
      m_count    = 16'h0000;
      m_mode     = M_IDLE;
      m_step_q   = 1'b0;
    end else begin
      m_acc    = m_valid && instr_ready;
      m_edge   = step && !m_step_q;
      m_step_q = step;
      if (m_acc && m_count != 16'hFFFF)
        m_count = m_count + 16'd1;
      if (redirect_valid) begin
        m_pc    = redirect_pc;
        m_valid = 1'b0;
      end else begin
        m_prev_valid = m_valid;
        m_load = (m_mode == M_RUN || m_mode == M_STEP) && (!m_valid || instr_ready);
        if (m_load) begin
          m_instr    = code_mem[m_pc];
          m_instr_pc = m_pc;
          m_valid    = 1'b1;
          m_pc       = m_pc + 5'd1;
        end else if (m_acc) begin
          m_valid = 1'b0;
        end
        case (m_mode)
          M_IDLE:  m_mode = run ? M_RUN : (m_edge ? M_STEP : M_IDLE);
          M_RUN:   m_mode = run ? M_RUN : M_DRAIN;
          M_STEP:  m_mode = m_load ? M_DRAIN : M_STEP;
          default: m_mode = (!m_prev_valid || m_acc) ? M_IDLE : M_DRAIN;
        endcase
      end
    end
    #1;
    if (cmp_on) begin
      checkOutput("model pc", 32'(pc), 32'(m_pc));
      checkOutput("model instr", 32'(instr), 32'(m_instr));
      checkOutput("model instr_pc", 32'(instr_pc), 32'(m_instr_pc));
      checkOutput("model instr_valid", 32'(instr_valid), 32'(m_valid));
      checkOutput("model fetch_count", 32'(fetch_count), 32'(m_count));
      checkOutput("model mode", 32'(mode), 32'(m_mode));
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 32; k++)
      code_mem[k] = 16'h4000 + 16'(k) * 16'h0111;
    code_mem[0]  = 16'hD300;
    code_mem[1]  = 16'hF104;
    code_mem[17] = 16'h1234;
    for (int k = 0; k < 16; k++) begin
      code_low[16*k +: 16]  = code_mem[k];
      code_high[16*k +: 16] = code_mem[16+k];
    end

    cycles(2);
    cmp_on = 1'b1;
    checkOutput("reset pc", 32'(pc), 0);
    checkOutput("reset instr", 32'(instr), 0);
    checkOutput("reset valid", 32'(instr_valid), 0);
    checkOutput("reset count", 32'(fetch_count), 0);
    checkOutput("reset mode", 32'(mode), 0);

    // Free run across the whole program and the wrap back to PC 0.
    Reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    cycles(1);
    checkOutput("run entry mode", 32'(mode), 1);
    checkOutput("run entry valid", 32'(instr_valid), 0);
    cycles(1);
    checkOutput("first instr_pc", 32'(instr_pc), 0);
    checkOutput("first instr", 32'(instr), 'hD300);
    checkOutput("first valid", 32'(instr_valid), 1);
    checkOutput("first count", 32'(fetch_count), 0);
    for (int k = 1; k <= 32; k++) begin
      cycles(1);
      checkOutput("stream instr_pc", 32'(instr_pc), k % 32);
      checkOutput("stream count", 32'(fetch_count), k);
      if (k == 1)  checkOutput("instr pc1", 32'(instr), 'hF104);
      if (k == 17) checkOutput("instr pc17", 32'(instr), 'h1234);
    end

    // Backpressure on the second pass at PC 5.
    cycles(5);
    checkOutput("bp instr_pc", 32'(instr_pc), 5);
    checkOutput("bp count", 32'(fetch_count), 37);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      checkOutput("bp hold instr_pc", 32'(instr_pc), 5);
      checkOutput("bp hold pc", 32'(pc), 6);
      checkOutput("bp hold instr", 32'(instr), 'h4555);
      checkOutput("bp hold count", 32'(fetch_count), 37);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    cycles(1);
    checkOutput("bp resume instr_pc", 32'(instr_pc), 6);
    checkOutput("bp resume count", 32'(fetch_count), 38);

    // Redirect to 20 while an instruction is being accepted.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd20, 1'b1);
    cycles(1);
    checkOutput("redir valid", 32'(instr_valid), 0);
    checkOutput("redir count", 32'(fetch_count), 39);
    checkOutput("redir pc", 32'(pc), 20);
    checkOutput("redir mode", 32'(mode), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
    cycles(1);
    checkOutput("redir target instr_pc", 32'(instr_pc), 20);
    checkOutput("redir target instr", 32'(instr), 'h5554);
    checkOutput("redir target valid", 32'(instr_valid), 1);
    checkOutput("redir target count", 32'(fetch_count), 39);

    // Asynchronous reset between clock edges.
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("async pc", 32'(pc), 0);
    checkOutput("async instr", 32'(instr), 0);
    checkOutput("async instr_pc", 32'(instr_pc), 0);
    checkOutput("async valid", 32'(instr_valid), 0);
    checkOutput("async count", 32'(fetch_count), 0);
    checkOutput("async mode", 32'(mode), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cycles(1);
    Reset_n = 1'b1;
    cycles(3);
    checkOutput("post reset mode", 32'(mode), 0);
    checkOutput("post reset valid", 32'(instr_valid), 0);
    checkOutput("post reset pc", 32'(pc), 0);

    // Single step with step held high and the decoder stalled.
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    cycles(5);
    checkOutput("step mode", 32'(mode), 3);
    checkOutput("step instr_pc", 32'(instr_pc), 0);
    checkOutput("step instr", 32'(instr), 'hD300);
    checkOutput("step valid", 32'(instr_valid), 1);
    checkOutput("step pc", 32'(pc), 1);
    checkOutput("step count", 32'(fetch_count), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("step done mode", 32'(mode), 0);
    checkOutput("step done pc", 32'(pc), 1);
    checkOutput("step done count", 32'(fetch_count), 1);
    checkOutput("step done valid", 32'(instr_valid), 0);

    // Drop run while the held instruction is stalled.
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    cycles(2);
    checkOutput("drop pre instr_pc", 32'(instr_pc), 1);
    checkOutput("drop pre valid", 32'(instr_valid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    cycles(1);
    checkOutput("drop mode", 32'(mode), 3);
    checkOutput("drop instr", 32'(instr), 'hF104);
    checkOutput("drop instr_pc", 32'(instr_pc), 1);
    checkOutput("drop pc", 32'(pc), 2);
    checkOutput("drop valid", 32'(instr_valid), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    cycles(3);
    checkOutput("drained mode", 32'(mode), 0);
    checkOutput("drained valid", 32'(instr_valid), 0);
    checkOutput("drained pc", 32'(pc), 2);
    checkOutput("drained count", 32'(fetch_count), 2);

    cycles(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
